// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: default stopwatch constants and the wrap-aware split helper.
package lap_timer_pkg;
  localparam int TICK_DIV = 500000;
  localparam int CNT_W = 19;
  localparam int WRAP_VAL = 360000;
  localparam int LAP_DEPTH = 12;
  localparam int SEL_W = 4;
  // Difference of two timestamps on a WRAP_VAL circle; a negative raw difference means a wrap.
  function automatic logic [31:0] split_diff(input logic [31:0] a, input logic [31:0] b, input logic [31:0] wrap);
    return (a >= b) ? a - b : a - b + wrap;
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser for an active-low button plus a 1-cycle falling-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  assign sh_d = {sh_q[1:0], btn_n};
  assign fall = sh_q[2] & ~sh_q[1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh_q <= '1;
    else sh_q <= sh_d;
  end
endmodule

// File: rtl/lap_timer.sv
// lap_timer: prescaled stopwatch with a flop-based lap memory and a registered
// cumulative/split display selector.
module lap_timer #(
  parameter int TICK_DIV = lap_timer_pkg::TICK_DIV,
  parameter int CNT_W = lap_timer_pkg::CNT_W,
  parameter int WRAP_VAL = lap_timer_pkg::WRAP_VAL,
  parameter int LAP_DEPTH = lap_timer_pkg::LAP_DEPTH,
  parameter int SEL_W = lap_timer_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic             lap_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             split_mode,
  output logic [CNT_W-1:0] disp_val,
  output logic [SEL_W-1:0] lap_count,
  output logic             laps_full,
  output logic             lap_drop
);
  import lap_timer_pkg::*;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d, disp_val_q, disp_val_d, cur, prv;
  logic [CNT_W-1:0] lap_mem_q [LAP_DEPTH];
  logic [CNT_W-1:0] lap_mem_d [LAP_DEPTH];
  logic [SEL_W-1:0] lap_count_q, lap_count_d;
  logic [31:0] sd;
  logic lap_drop_q, lap_drop_d, lap_evt, tick, full, take;
  btn_sync_edge u_lap_btn (.clk(clk), .reset(reset), .btn_n(lap_n), .fall(lap_evt));
  assign tick = run && presc_q == PW'(TICK_DIV - 1);
  assign full = lap_count_q == SEL_W'(LAP_DEPTH);
  assign take = lap_evt && !full;
  assign sd = split_diff(32'(cur), 32'(prv), 32'(WRAP_VAL));
  always_comb begin
    presc_d = !run ? presc_q : tick ? '0 : presc_q + 1'b1;
    elapsed_d = !tick ? elapsed_q : (elapsed_q == CNT_W'(WRAP_VAL - 1)) ? '0 : elapsed_q + 1'b1;
    lap_count_d = take ? lap_count_q + 1'b1 : lap_count_q;
    lap_drop_d = lap_evt && full && !clr;
    lap_mem_d = lap_mem_q;
    cur = '0;
    prv = '0;
    // Lap write and the cur/prev read muxes share one loop so no index narrower than sel is needed.
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (take && lap_count_q == SEL_W'(i)) lap_mem_d[i] = elapsed_q;
      if (sel == SEL_W'(i + 1)) cur = lap_mem_q[i];
      if (sel == SEL_W'(i + 2)) prv = lap_mem_q[i];
      if (clr) lap_mem_d[i] = '0;
    end
    if (clr) begin
      presc_d = '0;
      elapsed_d = '0;
      lap_count_d = '0;
    end
    disp_val_d = (sel == '0) ? elapsed_q : (sel > lap_count_q) ? '0 : split_mode ? sd[CNT_W-1:0] : cur;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      elapsed_q <= '0;
      lap_count_q <= '0;
      lap_drop_q <= 1'b0;
      disp_val_q <= '0;
      lap_mem_q <= '{default: '0};
    end else begin
      presc_q <= presc_d;
      elapsed_q <= elapsed_d;
      lap_count_q <= lap_count_d;
      lap_drop_q <= lap_drop_d;
      disp_val_q <= disp_val_d;
      lap_mem_q <= lap_mem_d;
    end
  end
  assign disp_val = disp_val_q;
  assign lap_count = lap_count_q;
  assign laps_full = full;
  assign lap_drop = lap_drop_q;
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed and random checks of lap_timer against a time-count/queue reference model.
module tb_lap_timer;
  localparam int TD = 4, WV = 10, LD = 3, CW = 19, SW = 4;
  logic clk = 1'b0, reset = 1'b0, run = 1'b0, clr = 1'b0, lap_n = 1'b1, split_mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [CW-1:0] disp_val;
  logic [SW-1:0] lap_count;
  logic laps_full, lap_drop;
  int total = 0, bad = 0, run_cnt = 0;
  int laps[$];
  bit [2:0] hist = 3'b111;
  int cum[3] = '{2, 5, 7};
  int spl[3] = '{2, 3, 2};
  always #5 clk = ~clk;
  lap_timer #(.TICK_DIV(TD), .CNT_W(CW), .WRAP_VAL(WV), .LAP_DEPTH(LD), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .run(run), .clr(clr), .lap_n(lap_n), .sel(sel),
    .split_mode(split_mode), .disp_val(disp_val), .lap_count(lap_count),
    .laps_full(laps_full), .lap_drop(lap_drop));
  function automatic int cur_e();
    return (run_cnt / TD) % WV;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    run_cnt = 0;
    laps.delete();
    hist = 3'b111;
  endtask
  // One clock: the model predicts from the pre-edge state, then the DUT is sampled 1 time unit after the edge.
  task automatic step();
    int e, s, dexp, prev;
    bit evt, dexp_drop;
    e = cur_e();
    s = int'(sel);
    evt = hist[2] && !hist[1];
    prev = (s >= 2 && s <= laps.size()) ? laps[s-2] : 0;
    dexp = (s == 0) ? e : (s > laps.size()) ? 0 : split_mode ? (laps[s-1] - prev + WV) % WV : laps[s-1];
    dexp_drop = evt && laps.size() == LD && !clr;
    if (clr) begin
      run_cnt = 0;
      laps.delete();
    end else begin
      if (evt && laps.size() < LD) laps.push_back(e);
      if (run) run_cnt++;
    end
    hist = {hist[1:0], lap_n};
    @(posedge clk);
    #1;
    chk("disp_val", 32'(disp_val), dexp);
    chk("lap_count", 32'(lap_count), laps.size());
    chk("laps_full", 32'(laps_full), 32'(laps.size() == LD));
    chk("lap_drop", 32'(lap_drop), 32'(dexp_drop));
  endtask
  task automatic wait_for(input int v, input int phase);
    for (int i = 0; i < 400 && !(cur_e() == v && (phase < 0 || run_cnt % TD == phase)); i++) step();
    chk("wait_for", cur_e(), v);
  endtask
  task automatic lap_at(input int v);
    run = 1'b1;
    wait_for(v, -1);
    run = 1'b0;
    lap_n = 1'b0;
    repeat (2) step();
    lap_n = 1'b1;
    repeat (3) step();
    run = 1'b1;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp", 32'(disp_val), 0);
    chk("rst_count", 32'(lap_count), 0);
    chk("rst_full", 32'(laps_full), 0);
    chk("rst_drop", 32'(lap_drop), 0);
    reset = 1'b1;
    run = 1'b1;
    repeat (37) step();
    chk("elapsed_9", 32'(disp_val), 9);
    run = 1'b0;
    repeat (8) step();
    chk("paused_hold", 32'(disp_val), 9);
    run = 1'b1;
    repeat (3) step();
    chk("phase_kept_9", 32'(disp_val), 9);
    step();
    chk("wrap_0", 32'(disp_val), 0);
    do_clr();
    lap_at(2);
    lap_at(5);
    lap_at(7);
    run = 1'b0;
    chk("three_laps", 32'(lap_count), 3);
    chk("full", 32'(laps_full), 1);
    for (int k = 1; k <= 3; k++) begin
      sel = SW'(k);
      split_mode = 1'b0;
      step();
      chk("cum_lap", 32'(disp_val), cum[k-1]);
      split_mode = 1'b1;
      step();
      chk("split_lap", 32'(disp_val), spl[k-1]);
    end
    sel = '0;
    split_mode = 1'b0;
    lap_n = 1'b0;
    repeat (3) step();
    chk("drop_pulse", 32'(lap_drop), 1);
    step();
    chk("drop_one_cycle", 32'(lap_drop), 0);
    lap_n = 1'b1;
    repeat (3) step();
    sel = 4'd2;
    step();
    chk("mem_unchanged", 32'(disp_val), 5);
    sel = 4'd15;
    step();
    chk("sel_beyond_depth", 32'(disp_val), 0);
    sel = '0;
    do_clr();
    lap_at(8);
    lap_at(1);
    run = 1'b0;
    sel = 4'd2;
    split_mode = 1'b1;
    step();
    chk("split_wrap", 32'(disp_val), 3);
    sel = 4'd3;
    step();
    chk("sel_no_lap", 32'(disp_val), 0);
    sel = '0;
    split_mode = 1'b0;
    do_clr();
    run = 1'b1;
    wait_for(6, 1);
    lap_n = 1'b0;
    repeat (20) step();
    lap_n = 1'b1;
    repeat (3) step();
    chk("held_one_capture", 32'(lap_count), 1);
    run = 1'b0;
    sel = 4'd1;
    step();
    chk("tick_coincide", 32'(disp_val), 6);
    sel = '0;
    do_clr();
    lap_at(3);
    lap_at(4);
    repeat (5) step();
    reset = 1'b0;
    #2;
    chk("async_disp", 32'(disp_val), 0);
    chk("async_count", 32'(lap_count), 0);
    chk("async_full", 32'(laps_full), 0);
    chk("async_drop", 32'(lap_drop), 0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    run = 1'b0;
    lap_n = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_beats_lap", 32'(lap_count), 0);
    repeat (5) step();
    lap_n = 1'b1;
    sel = 4'd1;
    step();
    chk("clr_nothing_stored", 32'(disp_val), 0);
    repeat (400) begin
      run = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 60) == 0;
      if ($urandom_range(0, 5) == 0) lap_n = ~lap_n;
      sel = SW'($urandom_range(0, 15));
      split_mode = 1'($urandom_range(0, 1));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
